mem_interface: RTL and testbench

- Byte-addressed, big-endian data/instruction memory that sits directly downstream of the datapath.
- Consumes MAR (Address), DataIn, RW, MOV and the access-size bits.
- Produces DataOut and MOC for the datapath and control unit.
- Models a multi-cycle memory with a programmable wait-state counter and a level-sensitive MOV/MOC handshake.

---
 rtl/mem_interface.sv | 145 ++++++++++++++
 tb/tb_mem_interface.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Byte-addressed big-endian memory with a programmable wait-state counter and MOV/MOC handshake.
// Optional macro MEM_ALIGN_CHECK_EN: flag misaligned half/word accesses instead of forcing alignment.
module mem_interface #(
    parameter int unsigned AW      = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Busy,
    output logic        AddrErr
);
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_din;
    logic [1:0]      r_size;
    logic            r_sext;
    logic            r_rw;
    logic [31:0]     r_dout;
    logic            r_moc;
    logic            r_busy;
    logic            r_addrerr;
    logic [7:0]      r_mem [DEPTH];

    logic            w_access;
    logic            w_misalign;
    logic [AW-1:0]   w_a0, w_a1, w_a2, w_a3;
    logic [7:0]      w_b0, w_b1, w_b2, w_b3;
    logic [31:0]     w_rdata;
    logic            w_unused_addr;

    assign w_unused_addr = ^Address[31:AW];

    // The access happens on the single edge that leaves WAIT.
    assign w_access = (r_state == WAIT) && (r_cnt == CW'(0));

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                        (r_size[1] && (r_addr[1:0] != 2'b00));
    assign w_a0       = r_addr;
`else
    assign w_misalign = 1'b0;
    assign w_a0       = r_size[1]          ? {r_addr[AW-1:2], 2'b00} :
                        (r_size == 2'b01)  ? {r_addr[AW-1:1], 1'b0}  : r_addr;
`endif

    assign w_a1 = w_a0 + AW'(1);
    assign w_a2 = w_a0 + AW'(2);
    assign w_a3 = w_a0 + AW'(3);
    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    // Big-endian lane assembly with optional sign extension.
    always_comb begin
        w_rdata = {w_b0, w_b1, w_b2, w_b3};
        case (r_size)
            2'b00:   w_rdata = {{24{r_sext & w_b0[7]}}, w_b0};
            2'b01:   w_rdata = {{16{r_sext & w_b0[7]}}, w_b0, w_b1};
            default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (MOV) w_next = WAIT;
            WAIT:    if (r_cnt == CW'(0)) w_next = DONE;
            DONE:    if (!MOV) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_size    <= '0;
            r_sext    <= 1'b0;
            r_rw      <= 1'b0;
            r_dout    <= '0;
            r_moc     <= 1'b0;
            r_busy    <= 1'b0;
            r_addrerr <= 1'b0;
        end else begin
            r_state <= w_next;
            r_moc   <= (w_next == DONE);
            r_busy  <= (w_next == WAIT);
            if (r_state == IDLE && MOV) begin
                r_cnt  <= CW'(LATENCY);
                r_addr <= Address[AW-1:0];
                r_din  <= DataIn;
                r_size <= Size;
                r_sext <= SignExt;
                r_rw   <= RW;
            end else if (r_state == WAIT && r_cnt != CW'(0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_access && r_rw && !w_misalign) r_dout <= w_rdata;
            if (w_access)              r_addrerr <= w_misalign;
            else if (w_next != DONE)   r_addrerr <= 1'b0;
        end
    end

    // Memory array is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_access && !r_rw && !w_misalign) begin
            case (r_size)
                2'b00: r_mem[w_a0] <= r_din[7:0];
                2'b01: begin
                    r_mem[w_a0] <= r_din[15:8];
                    r_mem[w_a1] <= r_din[7:0];
                end
                default: begin
                    r_mem[w_a0] <= r_din[31:24];
                    r_mem[w_a1] <= r_din[23:16];
                    r_mem[w_a2] <= r_din[15:8];
                    r_mem[w_a3] <= r_din[7:0];
                end
            endcase
        end
    end

    assign DataOut = r_dout;
    assign MOC     = r_moc;
    assign Busy    = r_busy;
    assign AddrErr = r_addrerr;
endmodule

// File: tb/tb_mem_interface.sv
// Directed self-checking bench for mem_interface (LATENCY=2 main instance, LATENCY=0 second instance).
module tb_mem_interface;
    logic        clk = 1'b0;
    logic        reset;
    logic        mov, mov0, rw;
    logic [31:0] addr, din;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] dout, dout0;
    logic        moc, busy, aerr, moc0, busy0, aerr0;

    int checks   = 0;
    int failures = 0;

    mem_interface #(.AW(9), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MOV(mov), .RW(rw), .Address(addr), .DataIn(din),
        .Size(size), .SignExt(sext), .DataOut(dout), .MOC(moc), .Busy(busy), .AddrErr(aerr)
    );

    mem_interface #(.AW(9), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .MOV(mov0), .RW(rw), .Address(addr), .DataIn(din),
        .Size(size), .SignExt(sext), .DataOut(dout0), .MOC(moc0), .Busy(busy0), .AddrErr(aerr0)
    );

    always #5 clk = ~clk;

    // Full request/complete/release cycle on the LATENCY=2 instance.
    task automatic do_access(input logic i_rw, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic se,
                             output logic [31:0] rd, output int lat, output logic ae);
        int n;
        rw = i_rw; addr = a; din = d; size = sz; sext = se; mov = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (moc !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lat = (n >= 20) ? -1 : n;
        rd  = dout;
        ae  = aerr;
        mov = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mov = 1'b0; mov0 = 1'b0; rw = 1'b0; addr = '0; din = '0; size = '0; sext = 1'b0;
        #3;
        checks++; if (moc !== 1'b0)      begin failures++; $display("FAIL reset_moc got %b exp 0", moc); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (aerr !== 1'b0)     begin failures++; $display("FAIL reset_aerr got %b exp 0", aerr); end
        checks++; if (dout !== 32'h0)    begin failures++; $display("FAIL reset_dout got %h exp 0", dout); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        logic held;
        rw = 1'b0; size = 2'b10; addr = 32'h10; din = 32'h80FF7F01; sext = 1'b0; mov = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, moc} !== 2'b10) begin
                failures++; $display("FAIL hs_wait_edge%0d busy,moc got %b%b exp 10", e, busy, moc);
            end
        end
        @(posedge clk); #1;
        checks++; if ({busy, moc} !== 2'b01) begin failures++; $display("FAIL hs_done_edge3 busy,moc got %b%b exp 01", busy, moc); end
        din  = 32'h0;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (moc !== 1'b1) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL hs_moc_held got %b exp 1", held); end
        mov = 1'b0;
        @(posedge clk); #1;
        checks++; if (moc !== 1'b0) begin failures++; $display("FAIL hs_release got %b exp 0", moc); end
    endtask

    task automatic test_read_widths();
        logic [1:0]  sz_t [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        logic [31:0] ad_t [5] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h12};
        logic        se_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ex_t [5] = '{32'h80FF7F01, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        logic [31:0] rd;
        int          lat;
        logic        ae;
        for (int i = 0; i < 5; i++) begin
            do_access(1'b1, ad_t[i], 32'h0, sz_t[i], se_t[i], rd, lat, ae);
            checks++;
            if (rd !== ex_t[i]) begin failures++; $display("FAIL rd_width%0d got %h exp %h", i, rd, ex_t[i]); end
        end
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got %0d exp 3", lat); end
        do_access(1'b0, 32'h13, 32'h000000AB, 2'b00, 1'b0, rd, lat, ae);
        do_access(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (rd !== 32'h80FF7FAB) begin failures++; $display("FAIL byte_write got %h exp 80ff7fab", rd); end
        do_access(1'b0, 32'h13, 32'h00000001, 2'b00, 1'b0, rd, lat, ae);
        do_access(1'b1, 32'h13, 32'h0, 2'b00, 1'b1, rd, lat, ae);
        checks++; if (rd !== 32'h00000001) begin failures++; $display("FAIL byte_restore got %h exp 00000001", rd); end
    endtask

    task automatic test_drop();
        int          highs, first;
        logic [31:0] seen;
        rw = 1'b1; size = 2'b10; addr = 32'h10; sext = 1'b0; mov = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mov = 1'b0;
        highs = 0; first = -1; seen = 32'h0;
        for (int e = 2; e < 10; e++) begin
            @(posedge clk); #1;
            if (moc === 1'b1) begin
                highs++;
                if (first < 0) begin first = e; seen = dout; end
            end
        end
        checks++; if (highs !== 1)            begin failures++; $display("FAIL drop_pulse_len got %0d exp 1", highs); end
        checks++; if (first !== 3)            begin failures++; $display("FAIL drop_moc_edge got %0d exp 3", first); end
        checks++; if (seen !== 32'h80FF7F01)  begin failures++; $display("FAIL drop_data got %h exp 80ff7f01", seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          lat;
        logic        ae;
        do_access(1'b0, 32'h20, 32'h11223344, 2'b10, 1'b0, rd, lat, ae);
        do_access(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL rst_pre got %h exp 11223344", rd); end
        rw = 1'b0; addr = 32'h20; din = 32'h12345678; size = 2'b10; mov = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if ({moc, busy} !== 2'b00) begin failures++; $display("FAIL rst_mid_flags got %b%b exp 00", moc, busy); end
        checks++; if (dout !== 32'h0)        begin failures++; $display("FAIL rst_mid_dout got %h exp 0", dout); end
        mov = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        do_access(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL rst_mem_kept got %h exp 11223344", rd); end
        checks++; if (lat !== 3)           begin failures++; $display("FAIL rst_recover_lat got %0d exp 3", lat); end
    endtask

    task automatic test_align();
        logic [31:0] rd;
        int          lat;
        logic        ae;
        logic        exp_ae;
        logic [31:0] exp_rd;
`ifdef MEM_ALIGN_CHECK_EN
        exp_ae = 1'b1; exp_rd = 32'h80FF7F01;
`else
        exp_ae = 1'b0; exp_rd = 32'hDEADBEEF;
`endif
        do_access(1'b0, 32'h12, 32'hDEADBEEF, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (ae !== exp_ae)  begin failures++; $display("FAIL align_err got %b exp %b", ae, exp_ae); end
        checks++; if (aerr !== 1'b0)  begin failures++; $display("FAIL align_err_clear got %b exp 0", aerr); end
        do_access(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (rd !== exp_rd)  begin failures++; $display("FAIL align_data got %h exp %h", rd, exp_rd); end
        checks++; if (ae !== 1'b0)    begin failures++; $display("FAIL align_ok_err got %b exp 0", ae); end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int          lat;
        logic        ae;
        do_access(1'b0, 32'h00000210, 32'hCAFEF00D, 2'b10, 1'b0, rd, lat, ae);
        do_access(1'b1, 32'h00000010, 32'h0, 2'b10, 1'b0, rd, lat, ae);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL alias got %h exp cafef00d", rd); end
    endtask

    task automatic test_latency0();
        int n;
        rw = 1'b0; addr = 32'h30; din = 32'h5A5AA5A5; size = 2'b10; sext = 1'b0; mov0 = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (moc0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 1) begin failures++; $display("FAIL lat0_write_edges got %0d exp 1", n); end
        mov0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (moc0 !== 1'b0) begin failures++; $display("FAIL lat0_release got %b exp 0", moc0); end
        rw = 1'b1; mov0 = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (moc0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (dout0 !== 32'h5A5AA5A5) begin failures++; $display("FAIL lat0_read got %h exp 5a5aa5a5", dout0); end
        mov0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_read_widths();
        test_drop();
        test_reset_mid();
        test_align();
        test_alias();
        test_latency0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
